// File: rtl/victim_ctrl_pkg.sv
// Shared types for the data-side victim cache controller: address/line layouts,
// default sizing and the swap sequencer state encoding.
package victim_ctrl_pkg;

  localparam int D_TAG_W  = 26;
  localparam int D_SET_W  = 3;
  localparam int D_OFF_W  = 3;
  localparam int D_ADDR_W = D_TAG_W + D_SET_W + D_OFF_W;
  localparam int D_DATA_W = 64;
  localparam int D_LINE_W = D_DATA_W + 1;

  localparam int VICTIM_IDX_BITS = 2;

  typedef struct packed {
    logic [D_TAG_W-1:0] tag;
    logic [D_SET_W-1:0] set;
    logic [D_OFF_W-1:0] offset;
  } D_ADDR;

  typedef struct packed {
    logic                valid;
    logic [D_DATA_W-1:0] data;
  } D_CACHE_LINE;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_SWAP_RD = 2'd1,
    VC_SWAP_WR = 2'd2
  } VICTIM_CTRL_STATE;

  function automatic logic same_tag(input D_ADDR a, input D_ADDR b);
    return a.tag == b.tag;
  endfunction

endpackage

// File: rtl/victim_ctrl_evq.sv
// Eviction queue: small circular FIFO of evicted lines with a combinational
// tag-match forwarding port that returns the youngest matching entry.
module victim_evq
  import victim_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_push,
  input  logic [D_LINE_W-1:0] i_push_line,
  input  logic [D_ADDR_W-1:0] i_push_addr,
  input  logic                i_pop,
  output logic                o_ready,
  output logic                o_empty,
  output logic [D_LINE_W-1:0] o_head_line,
  output logic [D_ADDR_W-1:0] o_head_addr,
  input  logic [D_ADDR_W-1:0] i_fwd_addr,
  output logic                o_fwd_hit,
  output logic [D_LINE_W-1:0] o_fwd_line
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [D_LINE_W-1:0] r_line [DEPTH];
  logic [D_ADDR_W-1:0] r_addr [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic [PTR_W-1:0]    w_age [DEPTH];
  logic [DEPTH-1:0]    w_match;
  logic [PTR_W-1:0]    w_best_age;
  logic                w_hit;
  logic [D_LINE_W-1:0] w_hit_line;

  assign o_ready     = r_count < CNT_W'(DEPTH);
  assign o_empty     = r_count == '0;
  assign o_head_line = r_line[r_head];
  assign o_head_addr = r_addr[r_head];

  // Age 0 is the head (oldest); an entry is live when its age is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_age[gi]   = PTR_W'(gi) - r_head;
      assign w_match[gi] = ({1'b0, w_age[gi]} < r_count) &&
                           same_tag(D_ADDR'(r_addr[gi]), D_ADDR'(i_fwd_addr));
    end
  endgenerate

  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && (!w_hit || w_age[i] >= w_best_age)) begin
        w_hit      = 1'b1;
        w_hit_line = r_line[i];
        w_best_age = w_age[i];
      end
    end
  end

  assign o_fwd_hit  = w_hit;
  assign o_fwd_line = w_hit_line;

  always_ff @(posedge clock) begin
    if (i_push) begin
      r_line[r_tail] <= i_push_line;
      r_addr[r_tail] <= i_push_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/victim_ctrl.sv
// Victim cache sequencer: drains the eviction queue into the victim array,
// allocates slots (lowest free, else round-robin) and runs the two-step swap.
module victim_ctrl
  import victim_ctrl_pkg::*;
#(
  parameter int VICTIM_SIZE = 1 << VICTIM_IDX_BITS,
  parameter int EVQ_DEPTH   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_evict_valid,
  input  logic [D_LINE_W-1:0]            i_evict_line,
  input  logic [D_ADDR_W-1:0]            i_evict_addr,
  output logic                           o_evict_ready,
  input  logic [D_ADDR_W-1:0]            i_fwd_addr,
  output logic                           o_fwd_hit,
  output logic [D_LINE_W-1:0]            o_fwd_line,
  input  logic                           i_swap_req,
  input  logic [$clog2(VICTIM_SIZE)-1:0] i_swap_idx,
  input  logic [D_ADDR_W-1:0]            i_swap_addr,
  output logic                           o_swap_ack,
  output logic [$clog2(VICTIM_SIZE)-1:0] o_vc_rd_idx,
  input  logic [D_LINE_W-1:0]            i_vc_rd_line,
  output logic                           o_vc_wr_en,
  output logic [$clog2(VICTIM_SIZE)-1:0] o_vc_wr_idx,
  output logic [D_LINE_W-1:0]            o_vc_wr_line,
  output logic [D_ADDR_W-1:0]            o_vc_wr_tag,
  output logic                           o_dc_fill_en,
  output logic [D_ADDR_W-1:0]            o_dc_fill_addr,
  output logic [D_LINE_W-1:0]            o_dc_fill_line,
  input  logic [D_LINE_W-1:0]            i_dc_disp_line,
  input  logic [D_ADDR_W-1:0]            i_dc_disp_addr
);

  localparam int IDX_W = $clog2(VICTIM_SIZE);

  VICTIM_CTRL_STATE    r_state;
  VICTIM_CTRL_STATE    w_next_state;
  logic [IDX_W-1:0]    r_swap_idx;
  logic [D_ADDR_W-1:0] r_swap_addr;
  logic [D_LINE_W-1:0] r_swap_line;
  logic [VICTIM_SIZE-1:0] r_slot_valid;
  logic [IDX_W-1:0]    r_rr_ptr;

  logic                w_q_ready;
  logic                w_q_empty;
  logic [D_LINE_W-1:0] w_q_head_line;
  logic [D_ADDR_W-1:0] w_q_head_addr;
  logic                w_q_fwd_hit;
  logic [D_LINE_W-1:0] w_q_fwd_line;
  logic                w_push;
  logic                w_drain;
  logic                w_swap_start;
  logic                w_disp_valid;
  logic                w_any_free;
  logic [IDX_W-1:0]    w_free_idx;
  logic [IDX_W-1:0]    w_alloc_idx;

  assign w_push       = i_evict_valid && w_q_ready && !reset;
  assign w_swap_start = (r_state == VC_IDLE) && i_swap_req;
  assign w_drain      = (r_state == VC_IDLE) && !i_swap_req && !w_q_empty && !reset;
  assign w_disp_valid = i_dc_disp_line[D_LINE_W-1];

  victim_evq #(
    .DEPTH (EVQ_DEPTH)
  ) u_evq (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_line (i_evict_line),
    .i_push_addr (i_evict_addr),
    .i_pop       (w_drain),
    .o_ready     (w_q_ready),
    .o_empty     (w_q_empty),
    .o_head_line (w_q_head_line),
    .o_head_addr (w_q_head_addr),
    .i_fwd_addr  (i_fwd_addr),
    .o_fwd_hit   (w_q_fwd_hit),
    .o_fwd_line  (w_q_fwd_line)
  );

  assign o_evict_ready = w_q_ready && !reset;
  assign o_fwd_hit     = w_q_fwd_hit && !reset;
  assign o_fwd_line    = reset ? '0 : w_q_fwd_line;

  // Scan downwards so the lowest free index wins.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = VICTIM_SIZE - 1; i >= 0; i--) begin
      if (!r_slot_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx = w_any_free ? w_free_idx : r_rr_ptr;

  always_ff @(posedge clock) begin
    if (reset) r_state <= VC_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      VC_IDLE:    if (i_swap_req) w_next_state = VC_SWAP_RD;
      VC_SWAP_RD: w_next_state = VC_SWAP_WR;
      VC_SWAP_WR: w_next_state = VC_IDLE;
      default:    w_next_state = VC_IDLE;
    endcase
  end

  always_comb begin
    o_swap_ack     = 1'b0;
    o_vc_rd_idx    = '0;
    o_vc_wr_en     = 1'b0;
    o_vc_wr_idx    = '0;
    o_vc_wr_line   = '0;
    o_vc_wr_tag    = '0;
    o_dc_fill_en   = 1'b0;
    o_dc_fill_addr = '0;
    o_dc_fill_line = '0;
    if (!reset) begin
      case (r_state)
        VC_IDLE: begin
          if (w_drain) begin
            o_vc_wr_en   = 1'b1;
            o_vc_wr_idx  = w_alloc_idx;
            o_vc_wr_line = w_q_head_line;
            o_vc_wr_tag  = w_q_head_addr;
          end
        end
        VC_SWAP_RD: o_vc_rd_idx = r_swap_idx;
        VC_SWAP_WR: begin
          o_dc_fill_en   = 1'b1;
          o_dc_fill_addr = r_swap_addr;
          o_dc_fill_line = r_swap_line;
          o_swap_ack     = 1'b1;
          o_vc_wr_en     = 1'b1;
          o_vc_wr_idx    = r_swap_idx;
          // An empty displaced way leaves nothing to keep, so the slot is invalidated.
          if (w_disp_valid) begin
            o_vc_wr_line = i_dc_disp_line;
            o_vc_wr_tag  = i_dc_disp_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_rr_ptr     <= '0;
      r_swap_idx   <= '0;
      r_swap_addr  <= '0;
      r_swap_line  <= '0;
    end else begin
      if (w_swap_start) begin
        r_swap_idx  <= i_swap_idx;
        r_swap_addr <= i_swap_addr;
      end
      if (r_state == VC_SWAP_RD) r_swap_line <= i_vc_rd_line;
      if (w_drain) begin
        r_slot_valid[w_alloc_idx] <= 1'b1;
        if (!w_any_free) r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
      if (r_state == VC_SWAP_WR && !w_disp_valid) r_slot_valid[r_swap_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_victim_ctrl.sv
// Directed + randomized bench for victim_ctrl with a queue-based reference model
// of the eviction queue, slot allocation, swap sequencing and the victim array.
module tb_victim_ctrl;

  localparam int VS  = 4;
  localparam int EVQ = 2;

  typedef struct {
    logic [64:0] line;
    logic [31:0] addr;
  } ent_t;

  typedef struct {
    int          idx;
    logic [31:0] tag;
    int          cyc;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        evict_valid;
  logic [64:0] evict_line;
  logic [31:0] evict_addr;
  logic        evict_ready;
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic [64:0] fwd_line;
  logic        swap_req;
  logic [1:0]  swap_idx;
  logic [31:0] swap_addr;
  logic        swap_ack;
  logic [1:0]  vc_rd_idx;
  logic [64:0] vc_rd_line;
  logic        vc_wr_en;
  logic [1:0]  vc_wr_idx;
  logic [64:0] vc_wr_line;
  logic [31:0] vc_wr_tag;
  logic        dc_fill_en;
  logic [31:0] dc_fill_addr;
  logic [64:0] dc_fill_line;
  logic [64:0] dc_disp_line;
  logic [31:0] dc_disp_addr;

  // Victim storage array the controller drives (environment, not the model).
  logic [64:0] vc_mem [VS];
  assign vc_rd_line = vc_mem[vc_rd_idx];
  always @(posedge clock) if (vc_wr_en) vc_mem[vc_wr_idx] <= vc_wr_line;

  always #5 clock = ~clock;

  victim_ctrl #(.VICTIM_SIZE(VS), .EVQ_DEPTH(EVQ)) dut (
    .clock(clock), .reset(reset),
    .i_evict_valid(evict_valid), .i_evict_line(evict_line), .i_evict_addr(evict_addr),
    .o_evict_ready(evict_ready),
    .i_fwd_addr(fwd_addr), .o_fwd_hit(fwd_hit), .o_fwd_line(fwd_line),
    .i_swap_req(swap_req), .i_swap_idx(swap_idx), .i_swap_addr(swap_addr),
    .o_swap_ack(swap_ack),
    .o_vc_rd_idx(vc_rd_idx), .i_vc_rd_line(vc_rd_line),
    .o_vc_wr_en(vc_wr_en), .o_vc_wr_idx(vc_wr_idx), .o_vc_wr_line(vc_wr_line),
    .o_vc_wr_tag(vc_wr_tag),
    .o_dc_fill_en(dc_fill_en), .o_dc_fill_addr(dc_fill_addr), .o_dc_fill_line(dc_fill_line),
    .i_dc_disp_line(dc_disp_line), .i_dc_disp_addr(dc_disp_addr)
  );

  // Reference model state
  ent_t        mq[$];
  bit          m_valid [VS];
  int          m_rr;
  int          m_phase;
  int          m_idx;
  logic [31:0] m_addr;
  logic [64:0] m_line;
  logic [64:0] m_arr [VS];

  // Observations from the most recent cycle
  int          n_total, n_pass, n_fail, cyc, ack_count;
  logic        last_ready, last_hit, last_ack, last_wen;
  logic [64:0] last_fline, last_fill_line, last_wline;
  logic [1:0]  last_widx;
  logic [31:0] last_wtag;
  wr_t         wr_log[$];

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int tag);
    logic [5:0] low;
    low = 6'($urandom);
    return {tag[25:0], low};
  endfunction

  function automatic logic [64:0] mk_line();
    return {1'b1, $urandom, $urandom};
  endfunction

  task automatic step();
    logic        e_ready, e_hit, e_ack, e_wen, e_fill, e_tagchk, repl;
    logic [1:0]  e_ridx, e_widx;
    logic [64:0] e_fline, e_wline, e_fill_line;
    logic [31:0] e_wtag, e_fill_addr;
    int          slot;
    bit          drain, push;
    e_ready = 0; e_hit = 0; e_ack = 0; e_wen = 0; e_fill = 0; e_tagchk = 0; repl = 0;
    e_ridx = '0; e_widx = '0; e_fline = '0; e_wline = '0; e_fill_line = '0;
    e_wtag = '0; e_fill_addr = '0; slot = 0; drain = 0;
    @(negedge clock);
    if (!reset) begin
      e_ready = mq.size() < EVQ;
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].addr[31:6] == fwd_addr[31:6]) begin
          e_hit   = 1;
          e_fline = mq[k].line;
        end
      if (m_phase == 0 && !swap_req && mq.size() > 0) begin
        drain = 1;
        slot  = -1;
        for (int i = 0; i < VS; i++) if (!m_valid[i] && slot < 0) slot = i;
        repl = (slot < 0);
        if (repl) slot = m_rr;
        e_wen = 1; e_widx = 2'(slot); e_wline = mq[0].line; e_wtag = mq[0].addr; e_tagchk = 1;
      end else if (m_phase == 1) begin
        e_ridx = 2'(m_idx);
      end else if (m_phase == 2) begin
        e_fill = 1; e_fill_addr = m_addr; e_fill_line = m_line; e_ack = 1;
        e_wen = 1; e_widx = 2'(m_idx);
        if (dc_disp_line[64]) begin
          e_wline = dc_disp_line; e_wtag = dc_disp_addr; e_tagchk = 1;
        end
      end
    end
    check("evict_ready", evict_ready, e_ready);
    check("fwd_hit", fwd_hit, e_hit);
    check("fwd_line", fwd_line, e_fline);
    check("swap_ack", swap_ack, e_ack);
    check("vc_wr_en", vc_wr_en, e_wen);
    check("dc_fill_en", dc_fill_en, e_fill);
    if (reset || m_phase == 1) check("vc_rd_idx", vc_rd_idx, e_ridx);
    if (reset || e_wen) begin
      check("vc_wr_idx", vc_wr_idx, e_widx);
      check("vc_wr_line", vc_wr_line, e_wline);
    end
    if (reset || e_tagchk) check("vc_wr_tag", vc_wr_tag, e_wtag);
    if (reset || e_fill) begin
      check("dc_fill_addr", dc_fill_addr, e_fill_addr);
      check("dc_fill_line", dc_fill_line, e_fill_line);
    end
    last_ready = evict_ready; last_hit = fwd_hit; last_fline = fwd_line;
    last_ack = swap_ack; last_wen = vc_wr_en; last_widx = vc_wr_idx;
    last_wline = vc_wr_line; last_wtag = vc_wr_tag;
    if (swap_ack) begin
      ack_count++;
      last_fill_line = dc_fill_line;
      $display("cycle %0d: swap ack fill addr %h line %h", cyc, dc_fill_addr, dc_fill_line);
    end
    if (vc_wr_en) begin
      wr_log.push_back('{idx: int'(vc_wr_idx), tag: vc_wr_tag, cyc: cyc});
      $display("cycle %0d: array write slot %0d tag %h line %h", cyc, vc_wr_idx, vc_wr_tag, vc_wr_line);
    end
    @(posedge clock);
    if (reset) begin
      mq.delete();
      for (int i = 0; i < VS; i++) m_valid[i] = 0;
      m_rr = 0; m_phase = 0;
    end else begin
      push = evict_valid && (mq.size() < EVQ);
      case (m_phase)
        0: begin
          if (swap_req) begin
            m_idx = int'(swap_idx); m_addr = swap_addr; m_phase = 1;
          end else if (drain) begin
            m_arr[slot]   = mq[0].line;
            m_valid[slot] = 1;
            if (repl) m_rr = (m_rr + 1) % VS;
            void'(mq.pop_front());
          end
        end
        1: begin
          m_line = m_arr[m_idx]; m_phase = 2;
        end
        default: begin
          if (dc_disp_line[64]) m_arr[m_idx] = dc_disp_line;
          else begin
            m_arr[m_idx] = '0; m_valid[m_idx] = 0;
          end
          m_phase = 0;
        end
      endcase
      if (push) mq.push_back('{line: evict_line, addr: evict_addr});
    end
    #1;
    cyc++;
  endtask

  task automatic do_swap(input int idx, input bit dvalid, input int dtag);
    int n;
    swap_req     = 1;
    swap_idx     = 2'(idx);
    swap_addr    = mk_addr(int'($urandom_range(20, 30)));
    dc_disp_line = dvalid ? mk_line() : {1'b0, $urandom, $urandom};
    dc_disp_addr = mk_addr(dtag);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_ack && n < 6);
    check("swap_latency", n, 3);
    swap_req = 0;
  endtask

  task automatic push_evict(input int tag, output logic [64:0] line);
    line        = mk_line();
    evict_valid = 1;
    evict_line  = line;
    evict_addr  = mk_addr(tag);
    step();
    evict_valid = 0;
  endtask

  initial begin
    logic [64:0] l7, l9, la, lb;
    int acks_before;
    n_total = 0; n_pass = 0; n_fail = 0; cyc = 0; ack_count = 0;
    m_rr = 0; m_phase = 0; m_idx = 0; m_addr = '0; m_line = '0;
    for (int i = 0; i < VS; i++) begin
      m_valid[i] = 0; m_arr[i] = '0;
    end
    reset = 1; evict_valid = 1; evict_line = mk_line(); evict_addr = mk_addr(3);
    fwd_addr = evict_addr; swap_req = 0; swap_idx = '0; swap_addr = '0;
    dc_disp_line = '0; dc_disp_addr = '0;

    // Reset: all outputs low even with an offered evict
    step();
    step();
    reset = 0; evict_valid = 0;
    step();
    check("ready_after_reset", last_ready, 1'b1);
    check("no_write_after_reset", last_wen, 1'b0);

    // Tags 1..4 fill slots 0..3 on successive cycles
    wr_log.delete();
    for (int t = 1; t <= 4; t++) begin
      evict_valid = 1; evict_line = mk_line(); evict_addr = mk_addr(t);
      step();
    end
    evict_valid = 0;
    step(); step();
    check("t1_nwrites", wr_log.size(), 4);
    for (int k = 0; k < wr_log.size() && k < 4; k++) begin
      check("t1_slot", wr_log[k].idx, k);
      check("t1_tag", wr_log[k].tag >> 6, k + 1);
      check("t1_cycle", wr_log[k].cyc - wr_log[0].cyc, k);
    end

    // All full: round-robin replacement from rr_ptr=0
    wr_log.delete();
    push_evict(5, la);
    push_evict(6, lb);
    push_evict(7, l7);
    step(); step();
    check("t2_nwrites", wr_log.size(), 3);
    for (int k = 0; k < wr_log.size() && k < 3; k++) begin
      check("t2_slot", wr_log[k].idx, k);
      check("t2_tag", wr_log[k].tag >> 6, k + 5);
    end

    // Swap slot 2 with a valid displaced line (tag 9)
    do_swap(2, 1, 9);
    l9 = dc_disp_line;
    check("t3_fill_line", last_fill_line, l7);
    check("t3_wr_idx", last_widx, 2'd2);
    check("t3_wr_tag", last_wtag >> 6, 32'd9);
    step();

    // Same swap, empty displaced way: slot 2 invalidated, next evict reuses it
    do_swap(2, 0, 0);
    check("t4_fill_line", last_fill_line, l9);
    check("t4_wr_line", last_wline, 65'd0);
    wr_log.delete();
    push_evict(10, la);
    step();
    check("t4_realloc_n", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t4_realloc_slot", wr_log[0].idx, 2);

    // Queue fills during a swap; youngest forwarding; drain after ack
    swap_req = 1; swap_idx = 2'd0; swap_addr = mk_addr(25);
    dc_disp_line = mk_line(); dc_disp_addr = mk_addr(12);
    la = mk_line(); lb = mk_line();
    fwd_addr = mk_addr(11);
    evict_valid = 1; evict_line = la; evict_addr = mk_addr(11);
    step();
    evict_line = lb; evict_addr = mk_addr(11);
    step();
    check("t5_fwd_hit_a", last_hit, 1'b1);
    check("t5_fwd_line_a", last_fline, la);
    evict_line = mk_line(); evict_addr = mk_addr(13);
    step();
    check("t5_ack", last_ack, 1'b1);
    check("t5_full", last_ready, 1'b0);
    check("t5_fwd_young", last_fline, lb);
    swap_req = 0; evict_valid = 0;
    step();
    check("t5_drain1", last_wen, 1'b1);
    check("t5_drain1_slot", last_widx, 2'd3);
    check("t5_drain1_line", last_wline, la);
    step();
    check("t5_drain2", last_wen, 1'b1);
    check("t5_drain2_slot", last_widx, 2'd0);
    check("t5_drain2_line", last_wline, lb);
    step();
    check("t5_idle", last_wen, 1'b0);

    // Reset while in SWAP_RD drops the swap
    acks_before = ack_count;
    swap_req = 1; swap_idx = 2'd1; swap_addr = mk_addr(26);
    evict_valid = 1; evict_line = mk_line(); evict_addr = mk_addr(14);
    step();
    reset = 1; evict_valid = 0;
    step();
    reset = 0; swap_req = 0;
    step();
    check("t6_ready", last_ready, 1'b1);
    check("t6_empty", last_wen, 1'b0);
    step();
    check("t6_no_ack", ack_count, acks_before);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      if (!swap_req && $urandom_range(0, 5) == 0) begin
        swap_req = 1;
        swap_idx = 2'($urandom_range(0, VS - 1));
        swap_addr = mk_addr(int'($urandom_range(1, 6)));
      end
      evict_valid  = 1'($urandom_range(0, 1));
      evict_line   = mk_line();
      evict_addr   = mk_addr(int'($urandom_range(1, 6)));
      fwd_addr     = mk_addr(int'($urandom_range(1, 6)));
      dc_disp_line = {1'($urandom_range(0, 1)), $urandom, $urandom};
      dc_disp_addr = mk_addr(int'($urandom_range(1, 6)));
      step();
      if (last_ack) swap_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/victim_ctrl.md
# victim_ctrl

Sequencing controller for the data-side victim cache. Buffers lines evicted from the dcache in a small queue, drains them one per cycle into the victim array's single write port, and runs the two-step swap that moves a victim-hit line back into the dcache while pushing the displaced dcache line into the freed victim slot. It also owns slot allocation: free-slot tracking and round-robin replacement. It sits between the dcache miss/evict logic and the victim storage array.

## Interface
- VICTIM_SIZE, 4, victim entries (power of two, ≥2)
- EVQ_DEPTH, 2, eviction queue depth (power of two, ≥2)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- evict_valid  in  1  dcache offers an evicted line
- evict_line  in  D_CACHE_LINE  evicted line (valid bit set)
- evict_addr  in  D_ADDR  address of evicted line
- evict_ready  out  1  queue not full; transfer when evict_valid && evict_ready
- fwd_addr  in  D_ADDR  lookup address for queue forwarding
- fwd_hit  out  1  some queued entry's tag equals fwd_addr.tag
- fwd_line  out  D_CACHE_LINE  matching queued line (youngest on multiple match); '0 when no hit
- swap_req  in  1  dcache miss hit victim entry swap_idx; held until swap_ack
- swap_idx  in  $clog2(VICTIM_SIZE)  victim entry to swap
- swap_addr  in  D_ADDR  miss address
- swap_ack  out  1  one-cycle pulse, swap complete
- vc_rd_idx  out  $clog2(VICTIM_SIZE)  victim array read index (array read is combinational)
- vc_rd_line  in  D_CACHE_LINE  array read data
- vc_wr_en  out  1  victim array write strobe
- vc_wr_idx  out  $clog2(VICTIM_SIZE)  write index
- vc_wr_line  out  D_CACHE_LINE  write data (valid=0 means invalidate)
- vc_wr_tag  out  D_ADDR  address whose tag is stored with the line
- dc_fill_en  out  1  write swapped line into dcache
- dc_fill_addr  out  D_ADDR  fill address
- dc_fill_line  out  D_CACHE_LINE  fill data
- dc_disp_line  in  D_CACHE_LINE  line displaced by the fill, same cycle; valid=0 if the set way was empty
- dc_disp_addr  in  D_ADDR  displaced line address

## Operation
- State: eviction FIFO (head/tail pointers and count), slot_valid[VICTIM_SIZE], rr_ptr, FSM {IDLE, SWAP_RD, SWAP_WR}, latched swap_idx/swap_addr, captured line.
- IDLE with swap_req=1: latch swap_idx/swap_addr, go to SWAP_RD. No drain that cycle; swap has priority.
- IDLE with swap_req=0 and FIFO non-empty: pop head and write it to the victim array.
  - Slot is the lowest-index slot with slot_valid=0.
  - If all slots are valid, slot is rr_ptr; rr_ptr increments modulo VICTIM_SIZE. rr_ptr changes only on replacement.
  - Set slot_valid[slot].
- SWAP_RD: vc_rd_idx = latched idx; capture vc_rd_line; go to SWAP_WR.
- SWAP_WR: dc_fill_en=1 with the captured line and latched addr; swap_ack=1; return to IDLE.
  - If dc_disp_line.valid: vc_wr_en writes dc_disp_line/dc_disp_addr into the latched idx; slot stays valid.
  - Else: vc_wr_en writes line '0 to idx and clears slot_valid[idx].
- FIFO push and pop may occur in the same cycle; a full FIFO still accepts when popping? No: evict_ready depends on count only (count<EVQ_DEPTH), independent of pop.
- Forwarding compares all valid queue entries combinationally, including the head being popped this cycle.
- vc_wr_en is asserted at most once per cycle; the array has one write port, owned by the FSM outside IDLE.

## Timing
- Reset (synchronous): FIFO empty, slot_valid=0, rr_ptr=0, FSM=IDLE.
  - All outputs 0 during reset, including evict_ready; evict_ready=1 the first cycle after.
  - An in-flight swap is dropped with no swap_ack.
- Evict accepted at edge N is written to the array at edge N+1 at the earliest; no bypass into the array.
- Swap: request sampled in IDLE at cycle T; SWAP_RD at T+1; fill and swap_ack at T+2. 3-cycle occupancy; back-to-back swaps every 3 cycles.
- During a swap the FIFO still accepts pushes but does not drain; evict_ready falls only when full.
- FIFO pointers wrap modulo EVQ_DEPTH; count width is $clog2(EVQ_DEPTH)+1.

## Structure
- D_CACHE_LINE and D_ADDR come from sys_defs.svh. Add VICTIM_IDX_BITS and the FSM state enum VICTIM_CTRL_STATE there.
- One sub-module, victim_evq: parameterized FIFO with tag-match forwarding port.

## Test plan
- Push 4 evicts (tags 1..4) into an empty controller → writes to slots 0,1,2,3 on successive cycles; rr_ptr remains 0.
- With all slots full, push tag 5 then tag 6 → tag 5 writes slot 0, tag 6 writes slot 1; rr_ptr=2.
- swap_req idx=2 with dc_disp_line.valid=1 tag 9 → dc_fill_en and swap_ack at T+2 with slot 2's line; slot 2 rewritten with tag 9.
- Same swap with dc_disp_line.valid=0 → slot 2 invalidated; next evict lands in slot 2.
- Fill FIFO (2 entries) during a swap → evict_ready=0; both entries drain on the 2 cycles after swap_ack; fwd_addr tag equal to a queued tag → fwd_hit=1 with the correct line.
- Assert reset in SWAP_RD → no swap_ack, FIFO empty, evict_ready=1 the cycle after reset deasserts.
